// File: rtl/cv32e40s_lsu_resp_tracker.sv
// In-order LSU transfer tracker: counts outstanding OBI transfers, gives bufferable
// stores an early core response and logs their bus errors as a sticky imprecise error.
module cv32e40s_lsu_resp_tracker #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             we_i,
    input  logic             bufferable_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             ready_i,
    input  logic             resp_valid_i,
    input  logic             resp_err_i,
    output logic             resp_valid_o,
    output logic             resp_err_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             resp_store_o,
    output logic             imp_err_o,
    output logic [TAG_W-1:0] imp_err_tag_o,
    input  logic             imp_err_clr_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] bus_cnt_o,
    output logic [CNT_W-1:0] core_cnt_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [DEPTH-1:0] early_q, early_d;
    logic [DEPTH-1:0] store_q, store_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] bus_ptr_q, bus_ptr_d;
    logic [PTR_W-1:0] core_ptr_q, core_ptr_d;
    logic [CNT_W-1:0] bus_cnt_q, bus_cnt_d;
    logic [CNT_W-1:0] core_cnt_q, core_cnt_d;
    logic             imp_err_q, imp_err_d;
    logic [TAG_W-1:0] imp_err_tag_q, imp_err_tag_d;

    logic not_full, alloc, bus_ret, core_vld, head_early, new_imp_err;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

    assign not_full   = bus_cnt_q < CNT_MAX;
    assign ready_o    = ready_i & not_full;
    assign valid_o    = valid_i & not_full;
    assign alloc      = valid_o & ready_i;
    assign bus_ret    = resp_valid_i & (bus_cnt_q != '0);
    assign core_vld   = core_cnt_q != '0;
    assign head_early = early_q[core_ptr_q];

    // A non-early head may only take the bus response once every earlier early
    // entry has drained on the bus, i.e. core head and bus head coincide.
    assign resp_valid_o = core_vld &
                          (head_early | (resp_valid_i & (bus_cnt_q == core_cnt_q)));
    assign resp_err_o   = core_vld & ~head_early & resp_err_i;
    assign resp_tag_o   = tag_q[core_ptr_q];
    assign resp_store_o = store_q[core_ptr_q];

    assign new_imp_err   = bus_ret & early_q[bus_ptr_q] & resp_err_i;
    assign imp_err_o     = imp_err_q;
    assign imp_err_tag_o = imp_err_tag_q;
    assign busy_o        = (bus_cnt_q != '0) | valid_i;
    assign bus_cnt_o     = bus_cnt_q;
    assign core_cnt_o    = core_cnt_q;

    always_comb begin
        early_d       = early_q;
        store_d       = store_q;
        tag_d         = tag_q;
        wr_ptr_d      = wr_ptr_q;
        bus_ptr_d     = bus_ptr_q;
        core_ptr_d    = core_ptr_q;
        bus_cnt_d     = bus_cnt_q;
        core_cnt_d    = core_cnt_q;
        imp_err_d     = imp_err_q;
        imp_err_tag_d = imp_err_tag_q;

        if (alloc) begin
            early_d[wr_ptr_q] = we_i & bufferable_i;
            store_d[wr_ptr_q] = we_i;
            tag_d[wr_ptr_q]   = tag_i;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (bus_ret) bus_ptr_d = ptr_inc(bus_ptr_q);
        if (resp_valid_o) core_ptr_d = ptr_inc(core_ptr_q);

        case ({alloc, bus_ret})
            2'b10:   bus_cnt_d = bus_cnt_q + CNT_W'(1);
            2'b01:   bus_cnt_d = bus_cnt_q - CNT_W'(1);
            default: bus_cnt_d = bus_cnt_q;
        endcase
        case ({alloc, resp_valid_o})
            2'b10:   core_cnt_d = core_cnt_q + CNT_W'(1);
            2'b01:   core_cnt_d = core_cnt_q - CNT_W'(1);
            default: core_cnt_d = core_cnt_q;
        endcase

        // First error is kept; a clear in the same cycle lets the new error in.
        if (new_imp_err && (!imp_err_q || imp_err_clr_i)) begin
            imp_err_d     = 1'b1;
            imp_err_tag_d = tag_q[bus_ptr_q];
        end else if (imp_err_clr_i) begin
            imp_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            early_q       <= '0;
            store_q       <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
            wr_ptr_q      <= '0;
            bus_ptr_q     <= '0;
            core_ptr_q    <= '0;
            bus_cnt_q     <= '0;
            core_cnt_q    <= '0;
            imp_err_q     <= 1'b0;
            imp_err_tag_q <= '0;
        end else begin
            early_q       <= early_d;
            store_q       <= store_d;
            tag_q         <= tag_d;
            wr_ptr_q      <= wr_ptr_d;
            bus_ptr_q     <= bus_ptr_d;
            core_ptr_q    <= core_ptr_d;
            bus_cnt_q     <= bus_cnt_d;
            core_cnt_q    <= core_cnt_d;
            imp_err_q     <= imp_err_d;
            imp_err_tag_q <= imp_err_tag_d;
        end
    end

    // Responses with nothing outstanding are dropped by the logic above.
    a_no_stray_resp: assert property (@(posedge clk) disable iff (!rst_n)
        !(resp_valid_i && (bus_cnt_q == '0)))
        else $warning("bus response with no outstanding transfer ignored");

endmodule
